// File: rtl/rr_sel_arbiter4_pkg.sv
// Shared types, sizes and helpers for the 4-way round-robin select arbiter.
// The arbiter drives the select of a downstream 4:1 single-bit mux.
package rr_sel_arbiter4_pkg;

    localparam int NCH   = 4;
    localparam int SEL_W = 2;

    typedef enum logic {
        IDLE  = 1'b0,
        GRANT = 1'b1
    } state_e;

    function automatic logic [NCH-1:0] onehot4(input logic [SEL_W-1:0] s);
        logic [NCH-1:0] v;
        case (s)
            2'd0:    v = 4'b0001;
            2'd1:    v = 4'b0010;
            2'd2:    v = 4'b0100;
            2'd3:    v = 4'b1000;
            default: v = 4'b0000;
        endcase
        return v;
    endfunction

endpackage

// File: rtl/rr_sel_arbiter4_pick4.sv
// Combinational rotating priority search: first set request bit at
// ptr, ptr+1, ptr+2, ptr+3 (mod 4).
module rr_pick4
    import rr_sel_arbiter4_pkg::*;
(
    input  logic [NCH-1:0]   req_i,
    input  logic [SEL_W-1:0] ptr_i,
    output logic             any_o,
    output logic [SEL_W-1:0] idx_o
);

    logic [SEL_W-1:0] cand_s;

    // Scan from the farthest offset down so the nearest requester wins last.
    always_comb begin
        any_o  = 1'b0;
        idx_o  = ptr_i;
        cand_s = 2'b00;
        for (int i = NCH - 1; i >= 0; i--) begin
            cand_s = ptr_i + i[SEL_W-1:0];
            if (req_i[cand_s]) begin
                any_o = 1'b1;
                idx_o = cand_s;
            end else begin
                any_o = any_o;
            end
        end
    end

endmodule

// File: rtl/rr_sel_arbiter4.sv
// Round-robin arbiter producing a glitch-free registered select for a 4:1 mux.
// Grants are released on done, request withdrawal or hold timeout.
module rr_sel_arbiter4
    import rr_sel_arbiter4_pkg::*;
#(
    parameter int MAX_HOLD = 8,
    parameter int CNT_W    = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [NCH-1:0]   req,
    input  logic             done,
    output logic [SEL_W-1:0] sel,
    output logic [NCH-1:0]   gnt,
    output logic             gnt_valid,
    output logic             timeout
);

    localparam logic             TIMEOUT_EN = (MAX_HOLD != 0);
    localparam logic [CNT_W-1:0] HOLD_LIM   = CNT_W'(MAX_HOLD);
    // With the timeout disabled the counter simply parks at all-ones.
    localparam logic [CNT_W-1:0] CNT_SAT    = TIMEOUT_EN ? HOLD_LIM : {CNT_W{1'b1}};
    localparam logic [CNT_W-1:0] CNT_ONE    = CNT_W'(1);

    state_e           state_q, state_d;
    logic [SEL_W-1:0] ptr_q, ptr_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [SEL_W-1:0] sel_q, sel_d;
    logic [NCH-1:0]   gnt_q, gnt_d;
    logic             gnt_valid_q, gnt_valid_d;
    logic             timeout_q, timeout_d;

    logic             pick_any_s;
    logic [SEL_W-1:0] pick_idx_s;
    logic             rel_done_s, rel_wd_s, rel_to_s;

    rr_pick4 u_pick (
        .req_i (req),
        .ptr_i (ptr_q),
        .any_o (pick_any_s),
        .idx_o (pick_idx_s)
    );

    // Release causes, only meaningful while a grant is held.
    always_comb begin
        rel_done_s = done;
        rel_wd_s   = ~req[sel_q];
        rel_to_s   = TIMEOUT_EN && (cnt_q == HOLD_LIM);
    end

    // Next-state and next-output logic.
    always_comb begin
        state_d     = state_q;
        ptr_d       = ptr_q;
        cnt_d       = cnt_q;
        sel_d       = sel_q;
        gnt_d       = gnt_q;
        gnt_valid_d = gnt_valid_q;
        timeout_d   = 1'b0;
        case (state_q)
            IDLE: begin
                if (pick_any_s) begin
                    state_d     = GRANT;
                    sel_d       = pick_idx_s;
                    gnt_d       = onehot4(pick_idx_s);
                    gnt_valid_d = 1'b1;
                    cnt_d       = CNT_ONE;
                end else begin
                    gnt_d       = 4'b0000;
                    gnt_valid_d = 1'b0;
                    cnt_d       = {CNT_W{1'b0}};
                end
            end
            GRANT: begin
                if (rel_done_s || rel_wd_s || rel_to_s) begin
                    state_d     = IDLE;
                    gnt_d       = 4'b0000;
                    gnt_valid_d = 1'b0;
                    ptr_d       = sel_q + 2'd1;
                    cnt_d       = {CNT_W{1'b0}};
                    timeout_d   = rel_to_s && !rel_done_s && !rel_wd_s;
                end else if (cnt_q != CNT_SAT) begin
                    cnt_d = cnt_q + CNT_ONE;
                end else begin
                    cnt_d = cnt_q;
                end
            end
            default: begin
                state_d     = IDLE;
                gnt_d       = 4'b0000;
                gnt_valid_d = 1'b0;
                cnt_d       = {CNT_W{1'b0}};
            end
        endcase
    end

    // State and output registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= IDLE;
            ptr_q       <= 2'b00;
            cnt_q       <= {CNT_W{1'b0}};
            sel_q       <= 2'b00;
            gnt_q       <= 4'b0000;
            gnt_valid_q <= 1'b0;
            timeout_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            ptr_q       <= ptr_d;
            cnt_q       <= cnt_d;
            sel_q       <= sel_d;
            gnt_q       <= gnt_d;
            gnt_valid_q <= gnt_valid_d;
            timeout_q   <= timeout_d;
        end
    end

    assign sel       = sel_q;
    assign gnt       = gnt_q;
    assign gnt_valid = gnt_valid_q;
    assign timeout   = timeout_q;

endmodule

// File: tb/tb_rr_sel_arbiter4.sv
// Directed self-checking bench for rr_sel_arbiter4 (MAX_HOLD=8).
module tb_rr_sel_arbiter4;

    logic       clk = 1'b0;
    logic       rst;
    logic [3:0] req;
    logic       done;
    logic [1:0] sel;
    logic [3:0] gnt;
    logic       gnt_valid;
    logic       timeout;

    int errors = 0;
    int checks = 0;

    rr_sel_arbiter4 #(.MAX_HOLD(8), .CNT_W(4)) dut (
        .clk       (clk),
        .rst       (rst),
        .req       (req),
        .done      (done),
        .sel       (sel),
        .gnt       (gnt),
        .gnt_valid (gnt_valid),
        .timeout   (timeout)
    );

    always #5 clk = ~clk;

    // Inputs change and outputs are sampled on the falling edge.
    task automatic step();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic do_reset();
        rst = 1'b1; req = 4'b0000; done = 1'b0;
        step(); step();
        rst = 1'b0;
    endtask

    task automatic test_reset();
        do_reset();
        checks++;
        if ({sel, gnt, gnt_valid, timeout} !== 8'b00_0000_0_0) begin
            errors++;
            $display("FAIL reset: got sel=%0d gnt=%b v=%b to=%b want 0/0000/0/0", sel, gnt, gnt_valid, timeout);
        end
        done = 1'b1;
        step();
        done = 1'b0;
        checks++;
        if ({gnt, gnt_valid, timeout} !== 6'b0000_0_0) begin
            errors++;
            $display("FAIL idle_done: got gnt=%b v=%b to=%b want 0000/0/0", gnt, gnt_valid, timeout);
        end
    endtask

    task automatic test_single();
        req = 4'b0100;
        step();
        checks++;
        if ({sel, gnt, gnt_valid} !== 7'b10_0100_1) begin
            errors++;
            $display("FAIL single_grant: got sel=%0d gnt=%b v=%b want 2/0100/1", sel, gnt, gnt_valid);
        end
        done = 1'b1;
        step();
        done = 1'b0;
        req  = 4'b0000;
        checks++;
        if ({sel, gnt, gnt_valid, timeout} !== 8'b10_0000_0_0) begin
            errors++;
            $display("FAIL single_release: got sel=%0d gnt=%b v=%b to=%b want 2/0000/0/0", sel, gnt, gnt_valid, timeout);
        end
    endtask

    // ptr is 3 after serving ch2, so ch0 must beat ch1.
    task automatic test_wrap();
        req = 4'b0011;
        step();
        checks++;
        if ({sel, gnt, gnt_valid} !== 7'b00_0001_1) begin
            errors++;
            $display("FAIL wrap_grant: got sel=%0d gnt=%b v=%b want 0/0001/1", sel, gnt, gnt_valid);
        end
        req = 4'b0000;
        step();
        checks++;
        if ({gnt_valid, timeout} !== 2'b00) begin
            errors++;
            $display("FAIL wrap_withdraw: got v=%b to=%b want 0/0", gnt_valid, timeout);
        end
    endtask

    task automatic test_round_robin();
        logic [1:0] order [5];
        order[0] = 2'd0; order[1] = 2'd1; order[2] = 2'd2; order[3] = 2'd3; order[4] = 2'd0;
        do_reset();
        req = 4'b1111;
        for (int k = 0; k < 5; k++) begin
            step();
            checks++;
            if ({gnt_valid, sel} !== {1'b1, order[k]}) begin
                errors++;
                $display("FAIL rr_grant%0d: got v=%b sel=%0d want 1/%0d", k, gnt_valid, sel, order[k]);
            end
            step();
            step();
            done = 1'b1;
            step();
            done = 1'b0;
            checks++;
            if ({gnt_valid, gnt} !== 5'b0_0000) begin
                errors++;
                $display("FAIL rr_bubble%0d: got v=%b gnt=%b want 0/0000", k, gnt_valid, gnt);
            end
        end
        req = 4'b0000;
        step();
    endtask

    task automatic test_timeout();
        do_reset();
        req = 4'b0010;
        step();
        for (int c = 1; c <= 8; c++) begin
            checks++;
            if ({gnt_valid, timeout, sel} !== 4'b1_0_01) begin
                errors++;
                $display("FAIL hold_cycle%0d: got v=%b to=%b sel=%0d want 1/0/1", c, gnt_valid, timeout, sel);
            end
            step();
        end
        checks++;
        if ({gnt_valid, timeout} !== 2'b01) begin
            errors++;
            $display("FAIL timeout_pulse: got v=%b to=%b want 0/1", gnt_valid, timeout);
        end
        step();
        checks++;
        if ({gnt_valid, timeout, sel} !== 4'b1_0_01) begin
            errors++;
            $display("FAIL timeout_regrant: got v=%b to=%b sel=%0d want 1/0/1", gnt_valid, timeout, sel);
        end
        for (int c = 1; c < 8; c++) step();
        done = 1'b1;
        step();
        done = 1'b0;
        req  = 4'b0000;
        checks++;
        if ({gnt_valid, timeout} !== 2'b00) begin
            errors++;
            $display("FAIL timeout_with_done: got v=%b to=%b want 0/0", gnt_valid, timeout);
        end
        step();
    endtask

    task automatic test_withdraw_and_reset();
        do_reset();
        req = 4'b0010;
        step();
        step();
        checks++;
        if ({gnt_valid, sel} !== 3'b1_01) begin
            errors++;
            $display("FAIL withdraw_hold: got v=%b sel=%0d want 1/1", gnt_valid, sel);
        end
        req = 4'b0000;
        step();
        checks++;
        if ({gnt_valid, gnt, timeout} !== 6'b0_0000_0) begin
            errors++;
            $display("FAIL withdraw_release: got v=%b gnt=%b to=%b want 0/0000/0", gnt_valid, gnt, timeout);
        end
        req = 4'b0100;
        step();
        checks++;
        if ({sel, gnt, gnt_valid} !== 7'b10_0100_1) begin
            errors++;
            $display("FAIL midrst_grant: got sel=%0d gnt=%b v=%b want 2/0100/1", sel, gnt, gnt_valid);
        end
        rst = 1'b1;
        step();
        rst = 1'b0;
        req = 4'b0000;
        checks++;
        if ({sel, gnt, gnt_valid, timeout} !== 8'b00_0000_0_0) begin
            errors++;
            $display("FAIL midrst_outputs: got sel=%0d gnt=%b v=%b to=%b want 0/0000/0/0", sel, gnt, gnt_valid, timeout);
        end
    endtask

    task automatic test_stability();
        do_reset();
        req = 4'b0100;
        step();
        for (int i = 0; i < 6; i++) begin
            req = (i % 2 == 0) ? 4'b1101 : 4'b0100;
            step();
            checks++;
            if ({sel, gnt, gnt_valid} !== 7'b10_0100_1) begin
                errors++;
                $display("FAIL stable%0d: got sel=%0d gnt=%b v=%b want 2/0100/1", i, sel, gnt, gnt_valid);
            end
        end
        done = 1'b1;
        step();
        done = 1'b0;
        req  = 4'b0000;
        checks++;
        if ({sel, gnt_valid, timeout} !== 4'b10_0_0) begin
            errors++;
            $display("FAIL stable_release: got sel=%0d v=%b to=%b want 2/0/0", sel, gnt_valid, timeout);
        end
    endtask

    initial begin
        rst = 1'b1; req = 4'b0000; done = 1'b0;
        @(negedge clk);
        test_reset();
        test_single();
        test_wrap();
        test_round_robin();
        test_timeout();
        test_withdraw_and_reset();
        test_stability();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
